// File: rtl/cube_pkg.sv
// cube_pkg: shared constants and state encoding for the chunk writer
package cube_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int CHUNKS_PER_ROW = 16;
  localparam int BYTES_PER_CHUNK = 4;
  localparam int PACKET_BYTES = CHUNKS_PER_ROW * BYTES_PER_CHUNK;
  typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD} state_t;
endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts consecutive enabled, uncleared cycles; expired marks the TIMEOUT_CYCLES-th (clk, reset, clear, enable -> expired)
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    count <= (reset || clear || !enable) ? '0 : count + 1'b1;
  assign expired = enable && !clear && count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/chunk_writer.sv
// chunk_writer: parses SYNC/header/64-byte packets into 16 big-endian 32-bit chunk writes (byte stream in -> chunk/row strobes out)
module chunk_writer #(
  parameter logic [7:0] SYNC_BYTE = cube_pkg::SYNC_BYTE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] chunk_data,
  output logic [3:0]  chunk_data_addr,
  output logic        chunk_data_write_enable,
  output logic [3:0]  row_data_row_addr,
  output logic [1:0]  row_data_panel_addr,
  output logic        row_done,
  output logic        frame_error
);
  import cube_pkg::*;
  state_t state, next;
  logic [5:0] byte_count;
  logic [23:0] shift;
  logic accept, expired, hdr_ok, hdr_bad, pay_acc, last_byte;
  assign in_ready = !reset;
  assign accept = in_valid && in_ready;
  assign hdr_ok = state == HEADER && accept && in_data[7:6] == 2'b00;
  assign hdr_bad = state == HEADER && accept && in_data[7:6] != 2'b00;
  assign pay_acc = state == PAYLOAD && accept;
  assign last_byte = byte_count == 6'(PACKET_BYTES - 1);
  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle (
    .clk(clk),
    .reset(reset),
    .clear(accept || state == HUNT),
    .enable(state != HUNT),
    .expired(expired)
  );
  always_ff @(posedge clk)
    state <= reset ? HUNT : next;
  always_comb begin
    next = state;
    unique case (state)
      HUNT:    next = (accept && in_data == SYNC_BYTE) ? HEADER : HUNT;
      HEADER:  next = expired ? HUNT : hdr_ok ? PAYLOAD : hdr_bad ? HUNT : HEADER;
      PAYLOAD: next = (expired || (pay_acc && last_byte)) ? HUNT : PAYLOAD;
      default: next = HUNT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_count <= '0;
      shift <= '0;
      chunk_data <= '0;
      chunk_data_addr <= '0;
      chunk_data_write_enable <= 1'b0;
      row_data_row_addr <= '0;
      row_data_panel_addr <= '0;
      row_done <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      chunk_data_write_enable <= 1'b0;
      row_done <= 1'b0;
      frame_error <= expired || hdr_bad;
      byte_count <= pay_acc ? byte_count + 1'b1 : state == PAYLOAD ? byte_count : '0;
      if (hdr_ok) {row_data_panel_addr, row_data_row_addr} <= in_data[5:0];
      if (pay_acc) begin
        shift <= {shift[15:0], in_data};
        if (byte_count[1:0] == 2'(BYTES_PER_CHUNK - 1)) begin
          chunk_data <= {shift, in_data};
          chunk_data_addr <= byte_count[5:2];
          chunk_data_write_enable <= 1'b1;
          row_done <= last_byte;
        end
      end
    end
  end
endmodule

// File: tb/tb_chunk_writer.sv
// tb_chunk_writer: table-driven and randomized self-checking bench for chunk_writer
module tb_chunk_writer;
  localparam int TO = 1024;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clk = 0, reset = 1, in_valid = 0, in_ready;
  logic [7:0] in_data = 0;
  logic [31:0] chunk_data;
  logic [3:0] chunk_data_addr, row_data_row_addr;
  logic [1:0] row_data_panel_addr;
  logic chunk_data_write_enable, row_done, frame_error;
  chunk_writer #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chunk_data(chunk_data), .chunk_data_addr(chunk_data_addr),
    .chunk_data_write_enable(chunk_data_write_enable),
    .row_data_row_addr(row_data_row_addr), .row_data_panel_addr(row_data_panel_addr),
    .row_done(row_done), .frame_error(frame_error)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int cyc; logic [3:0] addr; logic [31:0] data; logic rd; logic [1:0] panel; logic [3:0] row;} wr_t;
  wr_t wq[$];
  int fe_q[$];
  int orphans = 0;
  always @(negedge clk)
    if (!reset) begin
      if (chunk_data_write_enable)
        wq.push_back('{cyc, chunk_data_addr, chunk_data, row_done, row_data_panel_addr, row_data_row_addr});
      if (frame_error) fe_q.push_back(cyc);
      if (row_done && !chunk_data_write_enable) orphans++;
    end
  int checks = 0, errors = 0;
  int acc_cyc[16];
  int last_acc;
  logic [7:0] pay[64];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    in_data = b;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_data = SYNC;
    last_acc = cyc;
  endtask
  task automatic idle(input int n);
    in_valid = 0;
    in_data = SYNC;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic make_pay(input int mode);
    for (int i = 0; i < 64; i++) begin
      pay[i] = mode == 0 ? 8'(i) : 8'($urandom);
      if (mode == 2 && i % 5 == 1) pay[i] = SYNC;
    end
  endtask
  task automatic send_payload(input int n_bytes, input bit toggle, input int gap_at, input int gap_len);
    for (int i = 0; i < n_bytes; i++) begin
      if (i == gap_at) idle(gap_len);
      if (toggle) while ($urandom_range(0, 2) == 0) idle(1);
      send_byte(pay[i]);
      if (i % 4 == 3) acc_cyc[i / 4] = last_acc;
    end
  endtask
  task automatic verify_writes(input int n, input logic [1:0] panel, input logic [3:0] row);
    chk("n_writes", 32'(wq.size()), 32'(n));
    for (int k = 0; k < n && wq.size() > 0; k++) begin
      wr_t w = wq.pop_front();
      chk($sformatf("addr[%0d]", k), 32'(w.addr), 32'(k));
      chk($sformatf("data[%0d]", k), w.data, {pay[4*k], pay[4*k+1], pay[4*k+2], pay[4*k+3]});
      chk($sformatf("row_done[%0d]", k), 32'(w.rd), 32'(k == 15));
      chk($sformatf("panel[%0d]", k), 32'(w.panel), 32'(panel));
      chk($sformatf("row[%0d]", k), 32'(w.row), 32'(row));
      chk($sformatf("latency[%0d]", k), w.cyc, acc_cyc[k]);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_chunk_data"}, chunk_data, 0);
    chk({tag, "_addr"}, 32'(chunk_data_addr), 0);
    chk({tag, "_we"}, 32'(chunk_data_write_enable), 0);
    chk({tag, "_row"}, 32'(row_data_row_addr), 0);
    chk({tag, "_panel"}, 32'(row_data_panel_addr), 0);
    chk({tag, "_row_done"}, 32'(row_done), 0);
    chk({tag, "_frame_error"}, 32'(frame_error), 0);
  endtask
  typedef struct {
    int lead_n; logic [7:0] lead0, lead1, hdr;
    int mode; bit toggle; int exp_fe; logic [1:0] exp_panel; logic [3:0] exp_row;
  } vec_t;
  vec_t vt[6];
  initial begin
    vt[0] = '{0, 8'h00, 8'h00, 8'h27, 0, 0, 0, 2'd2, 4'd7};
    vt[1] = '{2, 8'h11, 8'h22, 8'h05, 1, 0, 0, 2'd0, 4'd5};
    vt[2] = '{0, 8'h00, 8'h00, 8'hC1, 1, 0, 1, 2'd0, 4'd5};
    vt[3] = '{1, 8'h3C, 8'h00, 8'h3A, 2, 1, 0, 2'd3, 4'd10};
    vt[4] = '{0, 8'h00, 8'h00, 8'h80, 1, 0, 1, 2'd3, 4'd10};
    vt[5] = '{0, 8'h00, 8'h00, 8'h1F, 2, 1, 0, 2'd1, 4'd15};
    #1;
    chk("ready_in_reset", 32'(in_ready), 0);
    idle(3);
    check_idle_outputs("reset");
    reset = 0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 1);
    foreach (vt[n]) begin
      wq.delete();
      fe_q.delete();
      for (int i = 0; i < vt[n].lead_n; i++) send_byte(i == 0 ? vt[n].lead0 : vt[n].lead1);
      send_byte(SYNC);
      send_byte(vt[n].hdr);
      make_pay(vt[n].mode);
      if (vt[n].exp_fe == 0) send_payload(64, vt[n].toggle, -1, 0);
      idle(3);
      chk($sformatf("vec%0d_frame_errors", n), 32'(fe_q.size()), 32'(vt[n].exp_fe));
      verify_writes(vt[n].exp_fe == 0 ? 16 : 0, vt[n].exp_panel, vt[n].exp_row);
      chk($sformatf("vec%0d_panel_out", n), 32'(row_data_panel_addr), 32'(vt[n].exp_panel));
      chk($sformatf("vec%0d_row_out", n), 32'(row_data_row_addr), 32'(vt[n].exp_row));
    end
    for (int r = 0; r < 4; r++) begin
      logic [7:0] hdr;
      hdr = {2'b00, 6'($urandom)};
      wq.delete();
      fe_q.delete();
      make_pay(2);
      send_byte(SYNC);
      send_byte(hdr);
      send_payload(64, 1, -1, 0);
      idle(2);
      chk("rand_frame_errors", 32'(fe_q.size()), 0);
      verify_writes(16, hdr[5:4], hdr[3:0]);
    end
    wq.delete();
    fe_q.delete();
    make_pay(1);
    send_byte(SYNC);
    send_byte(8'h10);
    send_payload(6, 0, -1, 0);
    idle(TO + 4);
    chk("timeout_fe_count", 32'(fe_q.size()), 1);
    if (fe_q.size() > 0) chk("timeout_fe_cycle", fe_q[0], last_acc + TO);
    verify_writes(1, 2'd1, 4'd0);
    wq.delete();
    fe_q.delete();
    make_pay(1);
    send_byte(SYNC);
    send_byte(8'h2C);
    send_payload(64, 0, 6, TO - 1);
    idle(2);
    chk("gap_below_timeout_fe", 32'(fe_q.size()), 0);
    verify_writes(16, 2'd2, 4'd12);
    wq.delete();
    fe_q.delete();
    make_pay(1);
    send_byte(SYNC);
    send_byte(8'h27);
    send_payload(30, 0, -1, 0);
    reset = 1;
    #1;
    chk("ready_mid_reset", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check_idle_outputs("midreset");
    reset = 0;
    for (int i = 0; i < 34; i++) send_byte(8'h00);
    idle(TO + 10);
    chk("reset_frame_errors", 32'(fe_q.size()), 0);
    verify_writes(7, 2'd2, 4'd7);
    chk("orphan_row_done", 32'(orphans), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
